// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues word requests to instruction
// memory, buffers returned words with their PCs in a small FIFO and presents
// the FIFO head to decode. Taken branches flush the buffer and drop every
// in-flight wrong-path response.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response
// arriving while the FIFO is empty goes straight to decode in the same cycle.
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        incr_pc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] d_inst_o,
  output logic [31:0] d_pc_o,
  output logic        d_valid_o
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CRD_W  = CNT_W + 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  // Architectural state
  logic [31:0]      f_pc_q, f_pc_d;
  logic [31:0]      rpc_q, rpc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];
  logic [31:0]      pc_mem_d   [FIFO_DEPTH];
  logic [31:0]      inst_mem_q [FIFO_DEPTH];
  logic [31:0]      inst_mem_d [FIFO_DEPTH];

  // Per-cycle events
  logic             fifo_pop_c;
  logic             issue_c;
  logic             resp_keep_c;
  logic             byp_c;
  logic             byp_used_c;
  logic             push_c;
  logic [CRD_W-1:0] credit_c;

  // Circular pointer advance that wraps at FIFO_DEPTH, not at a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Request credit: buffered plus useful in-flight words, less the head that
  // decode consumes this cycle, must stay below the buffer depth
  always_comb begin
    fifo_pop_c = (count_q != '0) && incr_pc_i;
    credit_c   = CRD_W'(count_q) + CRD_W'(outst_q) - CRD_W'(discard_q)
               - CRD_W'(fifo_pop_c);
    imem_req_o  = !rst_i && !branch_taken_i && (credit_c < CRD_W'(FIFO_DEPTH));
    imem_addr_o = f_pc_q;
    issue_c     = imem_req_o && imem_gnt_i;
  end

  // Response acceptance and optional same-cycle bypass to decode
  always_comb begin
    resp_keep_c = imem_rvalid_i && (discard_q == '0);
`ifdef FETCH_BYPASS_EN
    byp_c      = resp_keep_c && (count_q == '0) && !branch_taken_i && !rst_i;
    byp_used_c = byp_c && incr_pc_i;
`else
    byp_c      = 1'b0;
    byp_used_c = 1'b0;
`endif
    push_c = resp_keep_c && !byp_used_c;
  end

  // Next-state for PC, counters and buffer; a redirect overrides push and pop
  always_comb begin
    f_pc_d     = f_pc_q;
    rpc_d      = rpc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (branch_taken_i) begin
      // Everything still in flight belongs to the wrong path
      f_pc_d    = branch_target_i;
      rpc_d     = branch_target_i;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      outst_d   = outst_q - CNT_W'(imem_rvalid_i);
      discard_d = outst_q - CNT_W'(imem_rvalid_i);
    end else begin
      if (issue_c) begin
        f_pc_d = f_pc_q + 32'd4;
      end
      outst_d = outst_q + CNT_W'(issue_c) - CNT_W'(imem_rvalid_i);
      if (imem_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (resp_keep_c) begin
        rpc_d = rpc_q + 32'd4;
      end
      if (push_c) begin
        pc_mem_d[wr_ptr_q]   = rpc_q;
        inst_mem_d[wr_ptr_q] = imem_rdata_i;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (fifo_pop_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(fifo_pop_c);
    end
  end

  // State registers with synchronous reset; buffer storage needs no reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_pc_q    <= RESET_PC;
      rpc_q     <= RESET_PC;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      f_pc_q    <= f_pc_d;
      rpc_q     <= rpc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Instruction buffer storage
  always_ff @(posedge clk_i) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  // Decode-side view: FIFO head, bypassed response, or NOP when nothing valid
  always_comb begin
    d_valid_o = !rst_i && ((count_q != '0) || byp_c);
    d_inst_o  = NOP;
    d_pc_o    = 32'h0000_0000;
    if (!rst_i && (count_q != '0)) begin
      d_inst_o = inst_mem_q[rd_ptr_q];
      d_pc_o   = pc_mem_q[rd_ptr_q];
    end else if (byp_c) begin
      d_inst_o = imem_rdata_i;
      d_pc_o   = rpc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (RESET_PC = 0x100, FIFO_DEPTH = 2) with an
// in-order instruction memory model whose returned word is ~address.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnt;
  logic        rvalid = 1'b0;
  logic [31:0] rdata  = 32'h0;
  logic        incr;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic        d_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  int mcyc   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;
  mem_req_t mq[$];

  fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .incr_pc_i      (incr),
    .branch_taken_i (br),
    .branch_target_i(tgt),
    .d_inst_o       (d_inst),
    .d_pc_o         (d_pc),
    .d_valid_o      (d_valid)
  );

  always #5 clk = ~clk;

  // Memory model: grant in cycle N returns the word in cycle N+lat
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (rvalid) void'(mq.pop_front());
      if (req && gnt) mq.push_back('{addr: addr, due: mcyc + lat});
    end
    mcyc = mcyc + 1;
    #1;
    if (mq.size() != 0 && mq[0].due <= mcyc) begin
      rvalid = 1'b1;
      rdata  = ~mq[0].addr;
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] pat;
    pat = 32'hB4D2_6E39;
    rst = 1'b1; gnt = 1'b1; incr = 1'b1; br = 1'b0; tgt = 32'h0;

    // Held in reset
    @(negedge clk); #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(d_valid), 32'd0);
    chk("rst_inst", d_inst, NOP);
    chk("rst_pc", d_pc, 32'h0);

    // Cycle 1: first request at RESET_PC
    @(negedge clk); rst = 1'b0; #1;
    chk("c1_req", 32'(req), 32'd1);
    chk("c1_addr", addr, 32'h100);
    chk("c1_valid", 32'(d_valid), 32'd0);

    // Cycle 2
    @(negedge clk); #1;
    chk("c2_addr", addr, 32'h104);
    chk("c2_valid", 32'(d_valid), 32'd0);

    // Cycles 3..6: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("s_valid", 32'(d_valid), 32'd1);
      chk("s_pc", d_pc, 32'h100 + 32'(4 * i));
      chk("s_inst", d_inst, ~(32'h100 + 32'(4 * i)));
      chk("s_addr", addr, 32'h108 + 32'(4 * i));
    end

    // Cycles 7..11: decode stalled, head held, requests stop
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); incr = 1'b0; #1;
      chk("st_pc", d_pc, 32'h110);
      chk("st_inst", d_inst, ~32'h110);
      chk("st_req", 32'(req), 32'd0);
    end

    // Cycles 12..14: release, nothing lost or duplicated
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); incr = 1'b1; #1;
      chk("rel_pc", d_pc, 32'h110 + 32'(4 * j));
      chk("rel_req", 32'(req), 32'd1);
      chk("rel_addr", addr, 32'h118 + 32'(4 * j));
    end

    // Cycles 15..16: switch to 3-cycle memory latency
    @(negedge clk); lat = 3; #1;
    chk("c15_pc", d_pc, 32'h11C);
    chk("c15_addr", addr, 32'h124);
    @(negedge clk); #1;
    chk("c16_pc", d_pc, 32'h120);
    chk("c16_addr", addr, 32'h128);

    // Cycle 17: redirect with two words in flight
    @(negedge clk); br = 1'b1; tgt = 32'h2000; #1;
    chk("br1_req", 32'(req), 32'd0);
    chk("br1_valid", 32'(d_valid), 32'd0);

    // Cycles 18..21: wrong-path words dropped, target fetched
    @(negedge clk); br = 1'b0; #1;
    chk("c18_addr", addr, 32'h2000);
    chk("c18_req", 32'(req), 32'd1);
    chk("c18_valid", 32'(d_valid), 32'd0);
    @(negedge clk); #1;
    chk("c19_addr", addr, 32'h2004);
    chk("c19_valid", 32'(d_valid), 32'd0);
    @(negedge clk); #1;
    chk("c20_req", 32'(req), 32'd0);
    chk("c20_valid", 32'(d_valid), 32'd0);
    @(negedge clk); #1;
    chk("c21_req", 32'(req), 32'd0);
    chk("c21_valid", 32'(d_valid), 32'd0);

    // Cycle 22: target word visible; redirect together with rvalid and pop
    @(negedge clk); br = 1'b1; tgt = 32'h3000; #1;
    chk("c22_valid", 32'(d_valid), 32'd1);
    chk("c22_pc", d_pc, 32'h2000);
    chk("c22_inst", d_inst, ~32'h2000);
    chk("c22_req", 32'(req), 32'd0);

    // Cycles 23..24: buffer empty, fetch restarts at the new target
    @(negedge clk); br = 1'b0; #1;
    chk("c23_valid", 32'(d_valid), 32'd0);
    chk("c23_addr", addr, 32'h3000);
    chk("c23_req", 32'(req), 32'd1);
    @(negedge clk); #1;
    chk("c24_valid", 32'(d_valid), 32'd0);
    chk("c24_addr", addr, 32'h3004);

    // Cycle 25: reset with two requests outstanding
    @(negedge clk); rst = 1'b1; lat = 1; #1;
    chk("mr_req", 32'(req), 32'd0);
    chk("mr_valid", 32'(d_valid), 32'd0);

    // Cycle 26: out of reset, first request back at RESET_PC
    @(negedge clk); rst = 1'b0; gnt = 1'b0; #1;
    chk("mr_next_valid", 32'(d_valid), 32'd0);
    chk("mr_next_req", 32'(req), 32'd1);
    chk("mr_next_addr", addr, 32'h100);

    // Grant backpressure then free-running: contiguous addresses and PCs
    exp_pc   = 32'h100;
    exp_addr = 32'h100;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gnt = (i < 30) ? pat[i] : 1'b1;
      #1;
      if (d_valid) begin
        chk("bp_pc", d_pc, exp_pc);
        chk("bp_inst", d_inst, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (req) begin
        chk("bp_addr", addr, exp_addr);
        if (gnt) exp_addr = exp_addr + 32'd4;
      end
    end
    chk("bp_progress", 32'(exp_pc >= 32'h120), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
